// File: rtl/sha1_core_arbiter.sv
// Round-robin arbiter that time-shares one SHA-1 core among NUM_REQ requesters.
// Define SHA1_ARB_TIMEOUT_EN to build the WAIT-state watchdog and the sticky timeout_err flag.

module sha1_core_arbiter_checker #(
   parameter int NUM_REQ = 4
) (
   input logic               clk,
   input logic               reset,
   input logic [NUM_REQ-1:0] grant,
   input logic [NUM_REQ-1:0] rsp_valid,
   input logic               core_start
);
   a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
   a_rsp_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));
   a_rsp_owned:    assert property (@(posedge clk) disable iff (reset) (rsp_valid & ~grant) == '0);
   a_start_owned:  assert property (@(posedge clk) disable iff (reset) core_start |-> (|grant));
endmodule

module sha1_core_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int SETTLE_CYCLES  = 80,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*512-1:0] req_data,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [159:0]           rsp_digest,
   output logic                   core_start,
   output logic [511:0]           core_data,
   input  logic [159:0]           core_q_data,
   input  logic                   core_q_done,
   output logic                   busy,
   output logic                   timeout_err
);
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ?
                            ((SETTLE_CYCLES > 4) ? SETTLE_CYCLES : 4) :
                            ((TIMEOUT_CYCLES > 4) ? TIMEOUT_CYCLES : 4);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PHASE_LAST  = CNT_W'(3);
   localparam logic [IDX_W:0]   NUM_REQ_W   = (IDX_W + 1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
`ifdef SHA1_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      START  = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4,
      GAP    = 3'd5
   } state_t;

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [IDX_W-1:0]   rr_ptr_r;

   logic [NUM_REQ-1:0] rot_s;
   logic [IDX_W-1:0]   offset_s;
   logic [IDX_W:0]     sum_s;
   logic [IDX_W-1:0]   pick_idx_s;
   logic [NUM_REQ-1:0] pick_onehot_s;
   logic [511:0]       pick_data_s;
   logic [IDX_W-1:0]   next_ptr_s;

   // Rotate requests so rr_ptr sits at bit 0; the lowest set bit is the next owner.
   always_comb begin
      rot_s    = NUM_REQ'({req, req} >> rr_ptr_r);
      offset_s = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         offset_s = rot_s[k] ? IDX_W'(k) : offset_s;
      end
      sum_s = {1'b0, rr_ptr_r} + {1'b0, offset_s};
      if (sum_s >= NUM_REQ_W) begin
         pick_idx_s = IDX_W'(sum_s - NUM_REQ_W);
      end else begin
         pick_idx_s = sum_s[IDX_W-1:0];
      end
      pick_onehot_s = NUM_REQ'(1'b1) << pick_idx_s;
      if (pick_idx_s == LAST_IDX) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = pick_idx_s + IDX_W'(1);
      end
   end

   // Select the winning requester's block.
   always_comb begin
      pick_data_s = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pick_data_s = (pick_idx_s == IDX_W'(k)) ? req_data[k*512 +: 512] : pick_data_s;
      end
   end

   // Transaction sequencer; grant and core_data are frozen from the grant edge until GAP ends.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         rr_ptr_r   <= '0;
         grant      <= '0;
         rsp_valid  <= '0;
         rsp_digest <= '0;
         core_start <= 1'b0;
         core_data  <= '0;
         busy       <= 1'b0;
`ifdef SHA1_ARB_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (|req) begin
                  grant     <= pick_onehot_s;
                  core_data <= pick_data_s;
                  rr_ptr_r  <= next_ptr_s;
                  busy      <= 1'b1;
                  cnt_r     <= '0;
                  state_r   <= SETTLE;
               end else begin
                  busy <= 1'b0;
               end
            end
            SETTLE: begin
               if (cnt_r == SETTLE_LAST) begin
                  cnt_r      <= '0;
                  core_start <= 1'b1;
                  state_r    <= START;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            START: begin
               if (cnt_r == PHASE_LAST) begin
                  cnt_r      <= '0;
                  core_start <= 1'b0;
                  state_r    <= WAIT;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            WAIT: begin
               if (core_q_done) begin
                  rsp_digest <= core_q_data;
                  rsp_valid  <= grant;
                  cnt_r      <= '0;
                  state_r    <= RESP;
`ifdef SHA1_ARB_TIMEOUT_EN
               end else if (cnt_r == TIMEOUT_LAST) begin
                  rsp_digest  <= '0;
                  rsp_valid   <= grant;
                  timeout_err <= 1'b1;
                  cnt_r       <= '0;
                  state_r     <= RESP;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
`else
               end else begin
                  state_r <= WAIT;
               end
`endif
            end
            RESP: begin
               rsp_valid <= '0;
               cnt_r     <= '0;
               state_r   <= GAP;
            end
            GAP: begin
               // Four low cycles let the core's start-edge detector re-arm.
               if (cnt_r == PHASE_LAST) begin
                  grant   <= '0;
                  busy    <= 1'b0;
                  cnt_r   <= '0;
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               grant      <= '0;
               rsp_valid  <= '0;
               core_start <= 1'b0;
               busy       <= 1'b0;
               cnt_r      <= '0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

`ifndef SHA1_ARB_TIMEOUT_EN
   assign timeout_err = 1'b0;
`endif

   sha1_core_arbiter_checker #(.NUM_REQ(NUM_REQ)) u_checker (
      .clk        (clk),
      .reset      (reset),
      .grant      (grant),
      .rsp_valid  (rsp_valid),
      .core_start (core_start)
   );
endmodule
